// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready word input, start/data/parity/stop framing,
// built-in bit-rate divider; every line-facing output comes straight from a flop.
module uart_tx_serializer #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned LSB_FIRST    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                parity_q;
    logic                tx_out_q;
    logic                tx_ready_q;
    logic                tx_busy_q;
    logic                tx_done_q;

    logic                bit_end_d;
    logic [DATA_W-1:0]   shift_d;
    logic                cur_bit_d;
    logic                next_bit_d;

    // The shift register always moves toward the end that feeds the line.
    always_comb begin
        bit_end_d = (cnt_q == CNT_LAST);
        if (LSB_FIRST != 0) begin
            shift_d    = shift_q >> 1;
            cur_bit_d  = shift_q[0];
            next_bit_d = shift_d[0];
        end else begin
            shift_d    = shift_q << 1;
            cur_bit_d  = shift_q[DATA_W-1];
            next_bit_d = shift_d[DATA_W-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every flop,
    // including the shift register, is cleared by the asynchronous reset so an
    // abandoned frame leaves nothing behind.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        shift_q    <= tx_data;
                        parity_q   <= (^tx_data) ^ (PARITY_ODD != 0);
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= START;
                        tx_out_q   <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end_d) begin
                        cnt_q    <= '0;
                        state_q  <= DATA;
                        tx_out_q <= cur_bit_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end_d) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q  <= PARITY;
                                tx_out_q <= parity_q;
                            end else begin
                                state_q  <= STOP;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            shift_q  <= shift_d;
                            tx_out_q <= next_bit_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end_d) begin
                        cnt_q    <= '0;
                        state_q  <= STOP;
                        tx_out_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    // idx_q is reused to count stop bits.
                    if (bit_end_d) begin
                        cnt_q <= '0;
                        if (idx_q == STOP_LAST) begin
                            idx_q      <= '0;
                            state_q    <= IDLE;
                            tx_ready_q <= 1'b1;
                            tx_busy_q  <= 1'b0;
                            tx_done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    tx_out_q   <= 1'b1;
                    tx_ready_q <= 1'b1;
                    tx_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: five configurations share one clock and
// reset; expected frames are queued at drive time and compared cycle by cycle.
module tb_uart_tx_serializer;

    localparam int N = 5;
    localparam int DW   [N] = '{8, 8, 8, 8, 5};
    localparam int CPB  [N] = '{4, 4, 4, 4, 2};
    localparam int PEN  [N] = '{0, 1, 1, 0, 1};
    localparam int PODD [N] = '{0, 0, 1, 0, 0};
    localparam int SB   [N] = '{1, 1, 1, 2, 1};
    localparam int LSB  [N] = '{1, 1, 1, 0, 1};

    typedef struct {
        int          idx;
        int          nbits;
        logic [15:0] bits;
    } frame_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [8:0]   tx_data_r [N];
    logic [N-1:0] tx_valid_r;
    logic [N-1:0] tx_ready_w;
    logic [N-1:0] tx_out_w;
    logic [N-1:0] tx_busy_w;
    logic [N-1:0] tx_done_w;

    frame_t exp_q [$];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_serializer #(
            .DATA_W      (DW[g]),
            .CLKS_PER_BIT(CPB[g]),
            .PARITY_EN   (PEN[g]),
            .PARITY_ODD  (PODD[g]),
            .STOP_BITS   (SB[g]),
            .LSB_FIRST   (LSB[g])
        ) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .tx_data (tx_data_r[g][DW[g]-1:0]),
            .tx_valid(tx_valid_r[g]),
            .tx_ready(tx_ready_w[g]),
            .tx_out  (tx_out_w[g]),
            .tx_busy (tx_busy_w[g]),
            .tx_done (tx_done_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {tx_out, tx_ready, tx_busy, tx_done}
    function automatic logic [3:0] status(input int idx);
        return {tx_out_w[idx], tx_ready_w[idx], tx_busy_w[idx], tx_done_w[idx]};
    endfunction

    function automatic frame_t make_frame(input int idx, input logic [8:0] d);
        frame_t f;
        int     n;
        logic   p;
        f.idx  = idx;
        f.bits = '0;
        n      = 1;
        p      = (PODD[idx] != 0);
        for (int j = 0; j < DW[idx]; j++) begin
            f.bits[n] = (LSB[idx] != 0) ? d[j] : d[DW[idx]-1-j];
            p         = p ^ d[j];
            n++;
        end
        if (PEN[idx] != 0) begin
            f.bits[n] = p;
            n++;
        end
        for (int s = 0; s < SB[idx]; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    task automatic drive(input int idx, input logic [8:0] d);
        tx_data_r[idx]  = d;
        tx_valid_r[idx] = 1'b1;
        exp_q.push_back(make_frame(idx, d));
    endtask

    // Entered 1ns after the handshake edge; leaves 1ns after the frame-end edge.
    task automatic run_frame(input int idx, input bit hold);
        frame_t f;
        int     flen;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        f    = exp_q.pop_front();
        flen = f.nbits * CPB[idx];
        check($sformatf("frame_idx%0d", idx), f.idx, idx);
        for (int c = 0; c < flen; c++) begin
            check($sformatf("cfg%0d_cyc%0d", idx, c), status(idx), {f.bits[c / CPB[idx]], 3'b010});
            if (hold) tx_data_r[idx] = 9'($urandom);
            @(posedge clock); #1;
        end
        check($sformatf("cfg%0d_done", idx), status(idx), 4'b1101);
    endtask

    task automatic single_frame(input int idx, input logic [8:0] d);
        drive(idx, d);
        @(posedge clock); #1;
        tx_valid_r[idx] = 1'b0;
        run_frame(idx, 1'b0);
        @(posedge clock); #1;
        check($sformatf("cfg%0d_done_clear", idx), status(idx), 4'b1100);
    endtask

    initial begin
        reset_n    = 1'b0;
        tx_valid_r = '0;
        for (int i = 0; i < N; i++) tx_data_r[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) check($sformatf("reset_cfg%0d", i), status(i), 4'b1100);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_after_reset", status(0), 4'b1100);

        single_frame(0, 9'h055);
        single_frame(1, 9'h0A7);
        single_frame(2, 9'h0A7);
        single_frame(3, 9'h0C0);
        single_frame(4, 9'h01F);

        // tx_valid stays high across a frame while tx_data churns.
        drive(0, 9'h096);
        @(posedge clock); #1;
        run_frame(0, 1'b1);
        drive(0, 9'h03A);
        @(posedge clock); #1;
        tx_valid_r[0] = 1'b0;
        run_frame(0, 1'b0);
        @(posedge clock); #1;
        check("b2b_done_clear", status(0), 4'b1100);

        // Reset during data bit 3 of 0xA5 (bit 3 = 0, so the line visibly returns to mark).
        tx_data_r[0]  = 9'h0A5;
        tx_valid_r[0] = 1'b1;
        @(posedge clock); #1;
        tx_valid_r[0] = 1'b0;
        repeat (4 * CPB[0] + 1) @(posedge clock);
        #1;
        check("pre_reset_bit3", status(0), 4'b0010);
        #2 reset_n = 1'b0;
        #1 check("async_reset", status(0), 4'b1100);
        @(posedge clock); #1;
        check("reset_held", status(0), 4'b1100);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        check("no_done_after_reset", status(0), 4'b1100);
        single_frame(0, 9'h03C);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parametrised UART transmit serializer with built-in bit-rate divider, start/stop framing, optional parity and selectable bit order. It is the next generation of our 8-bit load/shift parallel-to-serial register. It sits between the TX byte source (FIFO or register interface) and the serial pin, and accepts words over a valid/ready handshake. Each accepted word is emitted as one complete asynchronous serial frame with no external shift control.

## Interface

- DATA_W, 8, data bits per frame, legal 5..9
- CLKS_PER_BIT, 16, clock cycles per serial bit, legal ≥2
- PARITY_EN, 0, 1 appends a parity bit after the data bits
- PARITY_ODD, 0, 0 gives even parity, 1 gives odd parity; ignored when PARITY_EN=0
- STOP_BITS, 1, number of stop bits, legal 1 or 2
- LSB_FIRST, 1, 1 sends bit 0 first, 0 sends bit DATA_W-1 first

- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- tx_data  input  DATA_W  word to send, sampled only on handshake
- tx_valid  input  1  source has a word
- tx_ready  output  1  block can accept a word (IDLE only)
- tx_out  output  1  serial line, idle/mark = 1
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at frame completion

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, tx_ready=1, tx_busy=0.
  - The handshake (tx_valid & tx_ready at a rising edge) captures tx_data into the shift register, clears the bit-cycle counter and bit index, and moves to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Drives the current shift-register end bit: bit[0] if LSB_FIRST, else bit[DATA_W-1].
  - Shifts toward that end every CLKS_PER_BIT cycles.
  - After DATA_W bits, moves to PARITY if PARITY_EN, else to STOP.
- PARITY:
  - tx_out = XOR of the captured word, inverted when PARITY_ODD.
  - Computed from the captured copy, never from live tx_data.
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with a tx_done pulse.
- Bit-cycle counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. Width is clog2(CLKS_PER_BIT).
- tx_valid outside IDLE is ignored, and so are changes to tx_data after capture; there is no queueing.
- Reset (any time, including mid-frame), asynchronously:
  - tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE.
  - Counter, index and shift register cleared.
  - The partial frame is abandoned; nothing is resumed.

## Timing

- The handshake at edge k makes tx_out=0, tx_ready=0 and tx_busy=1 visible after edge k.
- Frame length: F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles. tx_out bit n is stable from edge k + n*CLKS_PER_BIT through edge k + (n+1)*CLKS_PER_BIT.
- At edge k+F the block returns to IDLE:
  - tx_out=1, tx_ready=1, tx_busy=0, tx_done=1 for exactly one cycle.
- Back-to-back: with tx_valid held high, the next handshake occurs at edge k+F+1. The minimum inter-frame gap is therefore one clock of mark, and start-bit edges are F+1 cycles apart.
- tx_ready is registered and has no combinational path from tx_valid.
- tx_out is driven from a flop and is glitch-free.

## Test plan

- **8N1, LSB first, 0x55, CLKS_PER_BIT=4:**
  - line is 0, 1,0,1,0,1,0,1,0, 1, each bit held 4 cycles;
  - tx_done pulses at edge k+40;
  - tx_ready is low for cycles k..k+39.
- **Parity, PARITY_EN=1, data 0xA7 (five ones):**
  - PARITY_ODD=0 gives parity bit 1; PARITY_ODD=1 gives 0;
  - F=44 cycles at CLKS_PER_BIT=4.
- **MSB first, STOP_BITS=2, data 0xC0:**
  - line is 0, 1,1,0,0,0,0,0,0, 1,1;
  - the stop phase lasts 8 cycles at CLKS_PER_BIT=4.
- **Handshake hygiene:**
  - hold tx_valid high with a new tx_data each cycle during a frame: exactly one frame is sent, carrying the word captured at edge k;
  - the next frame starts at edge k+F+1.
- **Mid-frame reset:**
  - assert reset_n=0 during DATA bit 3: tx_out=1, tx_ready=1 and tx_busy=0 immediately, without waiting for a clock, and no tx_done pulse;
  - after release, a new 0x3C frame transmits correctly.
- **DATA_W=5, CLKS_PER_BIT=2, even parity, data 0x1F:**
  - bits 1,1,1,1,1, parity 1, one stop bit;
  - F=16.
